vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blanking and strobe outputs.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] LP_H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] LP_V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] LP_H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] LP_V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] LP_HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] LP_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] LP_VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] LP_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Counters must be able to represent the last pixel and the last line.
  if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOT-1 or V_TOT-1");
  end

  function automatic logic f_in_window(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_hblnk;
  logic             r_vblnk;
  logic             r_de;
  logic             r_line_start;
  logic             r_frame_start;

  logic [CNT_W-1:0] w_hcount_nxt;
  logic [CNT_W-1:0] w_vcount_nxt;
  logic             w_line_nxt;
  logic             w_frame_nxt;
  logic             w_hblnk_nxt;
  logic             w_vblnk_nxt;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;

  // Next counter values; every registered output is decoded from these so
  // outputs always describe the pixel currently on hcount/vcount.
  always_comb begin
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    w_line_nxt   = 1'b0;
    w_frame_nxt  = 1'b0;
    if (en) begin
      if (r_hcount == LP_H_LAST) begin
        w_hcount_nxt = '0;
        w_line_nxt   = 1'b1;
        if (r_vcount == LP_V_LAST) begin
          w_vcount_nxt = '0;
          w_frame_nxt  = 1'b1;
        end else begin
          w_vcount_nxt = r_vcount + CNT_W'(1);
        end
      end else begin
        w_hcount_nxt = r_hcount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_hblnk_nxt = (w_hcount_nxt >= LP_H_ACT);
    w_vblnk_nxt = (w_vcount_nxt >= LP_V_ACT);
    w_hsync_nxt = f_in_window(w_hcount_nxt, LP_HS_START, LP_HS_END) ? HS_POL : ~HS_POL;
    w_vsync_nxt = f_in_window(w_vcount_nxt, LP_VS_START, LP_VS_END) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_de          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_hblnk       <= w_hblnk_nxt;
      r_vblnk       <= w_vblnk_nxt;
      r_de          <= !w_hblnk_nxt && !w_vblnk_nxt;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
    end else if (w_frame_nxt) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
